// File: rtl/dds_wave_gen_if.sv
// Bundle of the tone generator's control, ROM and sample-output signals.
// The generator uses the slave view. The environment uses the master view;
// the environment also models the external quarter-wave ROM.
interface dds_wave_gen_if #(
  parameter int PHASE_W = 16,
  parameter int LUT_AW  = 7,
  parameter int OUT_W   = 8
);
  logic               en;
  logic               tw_load;
  logic [PHASE_W-1:0] tw_in;
  logic [1:0]         mode_in;
  logic [1:0]         vol_in;
  logic [LUT_AW-1:0]  lut_addr;
  logic [OUT_W-2:0]   lut_data;
  logic [OUT_W-1:0]   wave_out;
  logic               sample_valid;

  modport master (
    output en, tw_load, tw_in, mode_in, vol_in, lut_data,
    input  lut_addr, wave_out, sample_valid
  );

  modport slave (
    input  en, tw_load, tw_in, mode_in, vol_in, lut_data,
    output lut_addr, wave_out, sample_valid
  );
endinterface

// File: rtl/dds_wave_gen.sv
// DDS tone generator.
// A binary phase accumulator advances once per sample tick. The tick comes
// from a built-in clock divider. A three-stage pipeline turns the phase
// into sine (through an external quarter-wave ROM), square, triangle or
// sawtooth samples, with shift attenuation. Samples are offset binary.
module dds_wave_gen #(
  parameter int PHASE_W  = 16,
  parameter int LUT_AW   = 7,
  parameter int OUT_W    = 8,
  parameter int TICK_DIV = 25000
) (
  input  logic            clk,
  input  logic            rst_n,
  dds_wave_gen_if.slave   bus
);

  localparam int                DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [OUT_W-1:0]  MID      = {1'b1, {(OUT_W-1){1'b0}}};

  // Shift attenuation followed by conversion to offset binary (wraps mod 2^OUT_W)
  function automatic logic [OUT_W-1:0] atten_offset(input logic signed [OUT_W-1:0] s,
                                                    input logic [1:0]               sh);
    logic signed [OUT_W-1:0] a;
    a = s >>> sh;
    return $unsigned(a) + MID;
  endfunction

  logic [DIV_W-1:0]   div_cnt;
  logic               tick;

  logic [PHASE_W-1:0] tw_sh;
  logic [1:0]         mode_sh;
  logic [1:0]         vol_sh;

  logic [PHASE_W-1:0] phase_p0;
  logic [1:0]         mode_p0;
  logic [1:0]         vol_p0;
  logic               mute_p0;
  logic               vld_p0;
  logic [1:0]         q_p0;
  logic [LUT_AW-1:0]  idx_p0;

  // Only the top OUT_W+1 phase bits feed the waveform forming.
  logic [OUT_W:0]     ptop_p1;
  logic [LUT_AW-1:0]  lut_addr_p1;
  logic [1:0]         mode_p1;
  logic [1:0]         vol_p1;
  logic               mute_p1;
  logic               vld_p1;

  logic [OUT_W-1:0]   wave_p2;
  logic               vld_p2;

  logic [1:0]              q_p1;
  logic [OUT_W-1:0]        tri_t;
  logic [OUT_W-1:0]        tri_u;
  logic signed [OUT_W-1:0] samp_s;

  assign tick = (div_cnt == DIV_LAST);

  // Sample-rate divider: count 0..TICK_DIV-1, tick on the last count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // Shadow configuration, written on every load strobe regardless of tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tw_sh   <= '0;
      mode_sh <= '0;
      vol_sh  <= '0;
    end else if (bus.tw_load) begin
      tw_sh   <= bus.tw_in;
      mode_sh <= bus.mode_in;
      vol_sh  <= bus.vol_in;
    end
  end

  // ---- stage 0: phase accumulate on tick; a disabled tick zeroes phase and mutes ----
  // Phase accumulator and active configuration, updated once per tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_p0 <= '0;
      mode_p0  <= '0;
      vol_p0   <= '0;
      mute_p0  <= 1'b0;
      vld_p0   <= 1'b0;
    end else begin
      vld_p0 <= tick;
      if (tick) begin
        mode_p0 <= mode_sh;
        vol_p0  <= vol_sh;
        if (bus.en) begin
          phase_p0 <= phase_p0 + tw_sh;
          mute_p0  <= 1'b0;
        end else begin
          phase_p0 <= '0;
          mute_p0  <= 1'b1;
        end
      end
    end
  end

  assign q_p0   = phase_p0[PHASE_W-1 -: 2];
  assign idx_p0 = phase_p0[PHASE_W-3 -: LUT_AW];

  // ---- stage 1: quarter-mirrored ROM address, context piped alongside ----
  // ROM address plus the phase context, captured once per sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_addr_p1 <= '0;
      ptop_p1     <= '0;
      mode_p1     <= '0;
      vol_p1      <= '0;
      mute_p1     <= 1'b0;
      vld_p1      <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        lut_addr_p1 <= q_p0[0] ? ~idx_p0 : idx_p0;
        ptop_p1     <= phase_p0[PHASE_W-1 -: OUT_W+1];
        mode_p1     <= mode_p0;
        vol_p1      <= vol_p0;
        mute_p1     <= mute_p0;
      end
    end
  end

  assign bus.lut_addr = lut_addr_p1;

  assign q_p1  = ptop_p1[OUT_W -: 2];
  assign tri_t = ptop_p1[OUT_W-1:0];
  assign tri_u = ptop_p1[OUT_W] ? ~tri_t : tri_t;

  // Signed sample for the selected waveform; the lower half of sine is -1-mag.
  always_comb begin
    samp_s = '0;
    case (mode_p1)
      2'd0:    samp_s = q_p1[1] ? $signed(~{1'b0, bus.lut_data}) : $signed({1'b0, bus.lut_data});
      2'd1:    samp_s = q_p1[1] ? $signed(MID) : $signed(MID - 1'b1);
      2'd2:    samp_s = $signed(tri_u - MID);
      default: samp_s = $signed(ptop_p1[OUT_W:1] - MID);
    endcase
  end

  // ---- stage 2: attenuate, offset and register the output sample ----
  // Output register holds between samples; valid pulses for one cycle per sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave_p2 <= MID;
      vld_p2  <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) wave_p2 <= mute_p1 ? MID : atten_offset(samp_s, vol_p1);
    end
  end

  assign bus.wave_out     = wave_p2;
  assign bus.sample_valid = vld_p2;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Scoreboard bench for dds_wave_gen.
// A phase-level reference model pushes one expected sample per tick into a
// queue. A monitor pops from the queue and compares when the sample is due.
module tb_dds_wave_gen;
  localparam int PW = 16;
  localparam int AW = 7;
  localparam int OW = 8;
  localparam int TD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dds_wave_gen_if #(.PHASE_W(PW), .LUT_AW(AW), .OUT_W(OW)) bus();

  dds_wave_gen #(.PHASE_W(PW), .LUT_AW(AW), .OUT_W(OW), .TICK_DIV(TD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // external quarter-wave ROM
  logic [OW-2:0] rom_tab [0:(1<<AW)-1];
  assign bus.lut_data = rom_tab[bus.lut_addr];

  typedef struct {
    int val;
    int addr;
    int due;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passes = 0;
  int   edges  = 0;
  int   m_phase, sh_tw, sh_mode, sh_vol;

  function automatic int rom_val(input int a);
    real r;
    r = 127.0 * $sin(3.14159265358979 * real'(a) / 256.0);
    return int'($floor(r + 0.5));
  endfunction

  // Expected sample for a given phase, mode and volume, from the waveform definitions.
  function automatic int exp_wave(input int ph, input int mode, input int vol, output int addr);
    int quarter, pos, mag, t, u, s;
    quarter = ph / 16384;
    pos     = (ph / 128) % 128;
    addr    = (quarter % 2 == 1) ? 127 - pos : pos;
    case (mode)
      0: begin
        mag = rom_val(addr);
        s   = (quarter < 2) ? mag : -1 - mag;
      end
      1: s = (quarter < 2) ? 127 : -128;
      2: begin
        t = (ph / 128) % 256;
        u = (ph >= 32768) ? 255 - t : t;
        s = u - 128;
      end
      default: s = ph / 256 - 128;
    endcase
    return ((s >>> vol) + 128) & 255;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  // Reference model: acts on every rising edge, with inputs already settled.
  initial begin
    exp_t e;
    int   a;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        sbq.delete();
        m_phase = 0; sh_tw = 0; sh_mode = 0; sh_vol = 0; edges = 0;
      end else begin
        edges++;
        if (edges % TD == 0) begin
          if (bus.en) begin
            m_phase = (m_phase + sh_tw) % 65536;
            e.val   = exp_wave(m_phase, sh_mode, sh_vol, a);
            e.addr  = a;
          end else begin
            m_phase = 0;
            e.val   = 128;
            e.addr  = 0;
          end
          e.due = edges + 2;
          sbq.push_back(e);
        end
        if (bus.tw_load) begin
          sh_tw   = int'(bus.tw_in);
          sh_mode = int'(bus.mode_in);
          sh_vol  = int'(bus.vol_in);
        end
      end
    end
  end

  // Monitor: samples on the falling edge
  initial begin
    exp_t e;
    int   last;
    int   hold;
    last = -1;
    hold = 128;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last = -1;
        hold = 128;
      end else if (sbq.size() > 0 && sbq[0].due == edges) begin
        e = sbq.pop_front();
        check("sample_valid", int'(bus.sample_valid), 1);
        check("wave_out", int'(bus.wave_out), e.val);
        check("lut_addr", int'(bus.lut_addr), e.addr);
        if (last >= 0) check("valid_spacing", edges - last, TD);
        last = edges;
        hold = e.val;
      end else begin
        check("valid_idle", int'(bus.sample_valid), 0);
        check("wave_hold", int'(bus.wave_out), hold);
      end
    end
  end

  task automatic load(input int tw, input int mode, input int vol);
    @(negedge clk);
    bus.tw_load = 1'b1;
    bus.tw_in   = 16'(tw);
    bus.mode_in = 2'(mode);
    bus.vol_in  = 2'(vol);
    @(negedge clk);
    bus.tw_load = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    repeat (n * TD) @(negedge clk);
  endtask

  initial begin
    int n;
    for (int i = 0; i < (1 << AW); i++) rom_tab[i] = 7'(rom_val(i));
    bus.en = 1'b0; bus.tw_load = 1'b0; bus.tw_in = '0; bus.mode_in = '0; bus.vol_in = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_wave_out", int'(bus.wave_out), 128);
    check("rst_sample_valid", int'(bus.sample_valid), 0);
    check("rst_lut_addr", int'(bus.lut_addr), 0);
    rst_n = 1'b1;

    // first valid three cycles after the first tick (tick ends at edge 4)
    n = 0;
    while (!bus.sample_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("first_valid_latency", n, 6);

    // sawtooth through a full wrap
    bus.en = 1'b1;
    load(16'h0100, 3, 0);
    run_ticks(262);

    // square, full scale then halved
    load(16'h4000, 1, 0);
    run_ticks(8);
    load(16'h4000, 1, 1);
    run_ticks(8);

    // sine over a full period
    load(16'h0080, 0, 0);
    run_ticks(520);

    // triangle with attenuation
    load(16'h0123, 2, 2);
    run_ticks(40);

    // load strobe coincident with a tick
    load(16'h0100, 3, 0);
    run_ticks(2);
    do @(negedge clk); while ((edges + 1) % TD != 0);
    bus.tw_load = 1'b1; bus.tw_in = 16'h0200; bus.mode_in = 2'd3; bus.vol_in = 2'd0;
    @(negedge clk);
    bus.tw_load = 1'b0;
    run_ticks(6);

    // enable drop and phase-coherent restart
    bus.en = 1'b0;
    run_ticks(3);
    bus.en = 1'b1;
    run_ticks(5);

    // frozen phase
    load(16'h0000, 0, 0);
    run_ticks(4);

    // randomized configuration and enable activity
    repeat (80) begin
      case ($urandom_range(0, 3))
        0: load(int'($urandom_range(0, 65535)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        1: bus.en = ~bus.en;
        default: ;
      endcase
      repeat (int'($urandom_range(1, 12))) @(negedge clk);
    end
    bus.en = 1'b1;

    // asynchronous reset in mid-flight
    load(16'h0880, 0, 0);
    run_ticks(5);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_wave_out", int'(bus.wave_out), 128);
    check("async_rst_sample_valid", int'(bus.sample_valid), 0);
    check("async_rst_lut_addr", int'(bus.lut_addr), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load(16'h0400, 0, 1);
    run_ticks(20);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/dds_wave_gen.md
Name: dds_wave_gen

Overview:
Parametrised direct-digital-synthesis tone generator. It is the next generation of the keyboard-driven sine block.
- Replaces the fixed BCD-fraction stepping with a binary phase accumulator and a loadable tuning word.
- Adds square, triangle and sawtooth modes plus shift attenuation.
- Uses a built-in sample-rate divider and a pipelined quarter-wave LUT interface to an external distributed-ROM core.
- Sits between the scan-code decoder (which supplies tuning words) and the PWM/DAC output stage.

Parameters:
PHASE_W, 16, phase accumulator and tuning word width (min LUT_AW+2)
LUT_AW, 7, quarter-wave ROM address width
OUT_W, 8, output sample width, offset binary; ROM magnitude width is OUT_W-1
TICK_DIV, 25000, clk cycles per sample tick (100 MHz -> 4 kHz); min 1

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  generator enable, sampled at tick
tw_load  in  1  one-cycle strobe; captures tw_in, mode_in, vol_in into shadow registers
tw_in  in  PHASE_W  phase increment per tick
mode_in  in  2  0 sine, 1 square, 2 triangle, 3 sawtooth
vol_in  in  2  arithmetic right-shift attenuation, 0..3
lut_addr  out  LUT_AW  registered quarter-wave ROM address
lut_data  in  OUT_W-1  ROM magnitude, combinational from lut_addr
wave_out  out  OUT_W  registered sample, offset binary, MID = 2^(OUT_W-1)
sample_valid  out  1  one-cycle pulse when wave_out updates

Behaviour:
- Reset (async assert, sync release) clears: divider, phase, shadow/active tw, mode, vol, all pipeline registers and lut_addr to 0. wave_out resets to MID; sample_valid resets to 0. Asserting reset mid-pipeline discards in-flight samples.
- Divider: counter runs 0..TICK_DIV-1. tick is high in the cycle the count equals TICK_DIV-1, then the count wraps to 0. TICK_DIV=1 gives tick every cycle.
- Shadow config: tw_load writes the shadow registers whenever asserted, independent of tick.
- Stage 0, at a tick cycle n, with en=1:
  - active <= shadow; phase <= phase + shadow.tw, mod 2^PHASE_W.
  - If tw_load and tick coincide, this tick uses the old shadow. The new values apply at the next tick.
- Stage 0, at a tick with en=0: phase <= 0 and a mute flag is staged. The sample is still produced, with wave_out=MID.
- Stage 1 (cycle n+1 edge):
  - q = phase[PHASE_W-1:PHASE_W-2]; idx = phase[PHASE_W-3 -: LUT_AW].
  - lut_addr <= q[0] ? ~idx : idx (quarter mirroring).
  - q, phase, mode, vol and mute are piped alongside.
- Stage 2 (cycle n+2 edge): form signed s (OUT_W bits).
  - sine: q<2 ? +lut_data : -1-lut_data
  - square: q<2 ? MID-1 : -MID
  - triangle: t = phase[PHASE_W-2 -: OUT_W]; u = MSB ? ~t : t; s = u - MID
  - saw: s = phase[PHASE_W-1 -: OUT_W] - MID
  - wave_out <= mute ? MID : (s >>> vol) + MID, mod 2^OUT_W.
  - sample_valid <= 1 for exactly that cycle.
- Latency: new wave_out and sample_valid are visible in cycle n+3 relative to the tick cycle n.
- Between samples, wave_out holds and sample_valid=0.
- tw=0 with en=1: phase frozen, so a constant sample is re-emitted on every tick.
- Phase wrap is natural modular overflow with no special case.
- Mode/vol changes take effect only via tw_load followed by a tick. There is no mid-sample glitch.

Test Plan:
Parameters for all scenarios: PHASE_W=16, LUT_AW=7, OUT_W=8, TICK_DIV=4. ROM model: lut_data = round(127*sin(pi/2*a/128)).
1. Reset: assert rst_n=0 mid-run -> wave_out=128, sample_valid=0 and lut_addr=0 immediately (asynchronous). First valid appears 3 cycles after the first tick following release.
2. Saw: tw=0x0100, vol=0, en=1 -> k-th sample = k mod 256; wraps 255->0 at k=256; sample_valid spacing is exactly 4 clk.
3. Square: tw=0x4000 -> samples 255, 0, 0, 255 repeating. With vol=1 -> 191, 64, 64, 191.
4. Sine mirroring: tw=0x0080 -> lut_addr steps 1..127. At phase 0x4000 lut_addr=127, then descends. In quarters 2/3, wave_out = 127 - lut_data; peak sample 255, trough 0.
5. Load/tick collision: tw_load with tw_in=0x0200 in the same cycle as a tick -> that tick still advances by the old tw; the following tick advances by 0x0200.
6. Enable: drop en before a tick -> that sample is 128 and phase reads 0. Re-raise en -> first sample equals the phase=tw value (phase-coherent restart).
